// File: rtl/rca_config_bank_if.sv
// Configuration, use-tracking and map-output signals of the RCA configuration bank.
// The bank implements the slave side; the issue/config logic drives the master side.
interface rca_config_bank_if #(
  parameter int NUM_RCAS        = 3,
  parameter int NUM_READ_PORTS  = 5,
  parameter int NUM_WRITE_PORTS = 4,
  parameter int MAX_INFLIGHT    = 8
);
  localparam int RW   = (NUM_RCAS > 1) ? $clog2(NUM_RCAS) : 1;
  localparam int MAXP = (NUM_READ_PORTS > NUM_WRITE_PORTS) ? NUM_READ_PORTS : NUM_WRITE_PORTS;
  localparam int PW   = (MAXP > 1) ? $clog2(MAXP) : 1;
  localparam int CW   = $clog2(MAX_INFLIGHT + 1);

  // config write channel
  logic          cfg_valid;
  logic          cfg_ready;
  logic [RW-1:0] cfg_rca_sel;
  logic [PW-1:0] cfg_port_sel;
  logic          cfg_src_dest;
  logic [4:0]    cfg_reg_addr;
  logic          cfg_commit;
  logic          cfg_error;
  logic          commit_done;

  // use tracking
  logic          use_issue;
  logic [RW-1:0] use_issue_rca;
  logic          use_complete;
  logic [RW-1:0] use_complete_rca;

  // bank outputs
  logic [NUM_RCAS-1:0]                   rca_blocked;
  logic [NUM_RCAS*NUM_READ_PORTS*5-1:0]  rca_src_reg_addrs;
  logic [NUM_RCAS*NUM_WRITE_PORTS*5-1:0] rca_dest_reg_addrs;
  logic [NUM_RCAS*CW-1:0]                inflight_count;

  modport master (
    output cfg_valid, cfg_rca_sel, cfg_port_sel, cfg_src_dest, cfg_reg_addr, cfg_commit,
    output use_issue, use_issue_rca, use_complete, use_complete_rca,
    input  cfg_ready, cfg_error, commit_done,
    input  rca_blocked, rca_src_reg_addrs, rca_dest_reg_addrs, inflight_count
  );

  modport slave (
    input  cfg_valid, cfg_rca_sel, cfg_port_sel, cfg_src_dest, cfg_reg_addr, cfg_commit,
    input  use_issue, use_issue_rca, use_complete, use_complete_rca,
    output cfg_ready, cfg_error, commit_done,
    output rca_blocked, rca_src_reg_addrs, rca_dest_reg_addrs, inflight_count
  );
endinterface

// File: rtl/rca_config_bank.sv
// Per-RCA register-address map bank with shadow/active copies.
// Config writes land in the shadow copy; a commit waits for the target RCA's
// outstanding uses to drain, then copies its shadow maps to the active maps.
module rca_config_bank #(
  parameter int NUM_RCAS        = 3,
  parameter int NUM_READ_PORTS  = 5,
  parameter int NUM_WRITE_PORTS = 4,
  parameter int MAX_INFLIGHT    = 8
) (
  input logic              clk,
  input logic              rst,
  rca_config_bank_if.slave bus
);
  localparam int RW   = (NUM_RCAS > 1) ? $clog2(NUM_RCAS) : 1;
  localparam int MAXP = (NUM_READ_PORTS > NUM_WRITE_PORTS) ? NUM_READ_PORTS : NUM_WRITE_PORTS;
  localparam int PW   = (MAXP > 1) ? $clog2(MAXP) : 1;
  localparam int CW   = $clog2(MAX_INFLIGHT + 1);

  // one extra bit so the limits themselves are representable
  localparam logic [RW:0]   RCA_LIM = (RW+1)'(NUM_RCAS);
  localparam logic [PW:0]   RD_LIM  = (PW+1)'(NUM_READ_PORTS);
  localparam logic [PW:0]   WR_LIM  = (PW+1)'(NUM_WRITE_PORTS);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_INFLIGHT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [RW-1:0] commit_rca;
  logic          err_pulse;
  logic          done_pulse;

  logic [4:0] shadow_src  [NUM_RCAS][NUM_READ_PORTS];
  logic [4:0] shadow_dest [NUM_RCAS][NUM_WRITE_PORTS];
  logic [4:0] active_src  [NUM_RCAS][NUM_READ_PORTS];
  logic [4:0] active_dest [NUM_RCAS][NUM_WRITE_PORTS];
  logic [CW-1:0] count    [NUM_RCAS];

  logic cfg_acc;
  logic rca_ok;
  logic port_ok;
  logic wr_ok;
  logic wr_bad;
  logic drain_cnt_busy;
  logic drain_busy;

  logic [NUM_RCAS*NUM_READ_PORTS*5-1:0]  src_flat;
  logic [NUM_RCAS*NUM_WRITE_PORTS*5-1:0] dest_flat;
  logic [NUM_RCAS*CW-1:0]                cnt_flat;
  logic [NUM_RCAS-1:0]                   blocked;

  // Saturating up/down counter step: simultaneous inc/dec cancels, never
  // wraps past MAX_INFLIGHT or below zero.
  function automatic logic [CW-1:0] next_count(input logic [CW-1:0] cur,
                                               input logic inc,
                                               input logic dec);
    logic [CW-1:0] res;
    res = cur;
    if (inc && !dec && (cur != CNT_MAX)) begin
      res = cur + CW'(1);
    end else if (dec && !inc && (cur != '0)) begin
      res = cur - CW'(1);
    end
    return res;
  endfunction

  assign cfg_acc = bus.cfg_valid & bus.cfg_ready;
  assign rca_ok  = ({1'b0, bus.cfg_rca_sel} < RCA_LIM);
  assign port_ok = bus.cfg_src_dest ? ({1'b0, bus.cfg_port_sel} < WR_LIM)
                                    : ({1'b0, bus.cfg_port_sel} < RD_LIM);
  assign wr_ok   = cfg_acc & rca_ok & port_ok;
  assign wr_bad  = cfg_acc & ~(rca_ok & port_ok);

  // Outstanding-use count of the RCA currently being committed.
  always_comb begin
    drain_cnt_busy = 1'b0;
    for (int r = 0; r < NUM_RCAS; r++) begin
      if ((commit_rca == RW'(r)) && (count[r] != '0)) begin
        drain_cnt_busy = 1'b1;
      end
    end
  end

  // An issue to the draining RCA in the same cycle keeps the drain open.
  assign drain_busy = drain_cnt_busy | (bus.use_issue & (bus.use_issue_rca == commit_rca));

  // Commit FSM next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (wr_ok && bus.cfg_commit) state_nxt = DRAIN;
      DRAIN:   if (!drain_busy) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control state: FSM, committing RCA, and the one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      commit_rca <= '0;
      err_pulse  <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      err_pulse  <= wr_bad;
      done_pulse <= (state == COMMIT);
      if ((state == IDLE) && wr_ok && bus.cfg_commit) begin
        commit_rca <= bus.cfg_rca_sel;
      end
    end
  end

  // Shadow maps take every accepted in-range config write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_RCAS; r++) begin
        for (int p = 0; p < NUM_READ_PORTS; p++)  shadow_src[r][p]  <= '0;
        for (int p = 0; p < NUM_WRITE_PORTS; p++) shadow_dest[r][p] <= '0;
      end
    end else if (wr_ok) begin
      for (int r = 0; r < NUM_RCAS; r++) begin
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
          if (!bus.cfg_src_dest && (bus.cfg_rca_sel == RW'(r)) && (bus.cfg_port_sel == PW'(p))) begin
            shadow_src[r][p] <= bus.cfg_reg_addr;
          end
        end
        for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
          if (bus.cfg_src_dest && (bus.cfg_rca_sel == RW'(r)) && (bus.cfg_port_sel == PW'(p))) begin
            shadow_dest[r][p] <= bus.cfg_reg_addr;
          end
        end
      end
    end
  end

  // Active maps: whole-RCA copy from shadow in the COMMIT cycle only.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_RCAS; r++) begin
        for (int p = 0; p < NUM_READ_PORTS; p++)  active_src[r][p]  <= '0;
        for (int p = 0; p < NUM_WRITE_PORTS; p++) active_dest[r][p] <= '0;
      end
    end else if (state == COMMIT) begin
      for (int r = 0; r < NUM_RCAS; r++) begin
        if (commit_rca == RW'(r)) begin
          for (int p = 0; p < NUM_READ_PORTS; p++)  active_src[r][p]  <= shadow_src[r][p];
          for (int p = 0; p < NUM_WRITE_PORTS; p++) active_dest[r][p] <= shadow_dest[r][p];
        end
      end
    end
  end

  // Per-RCA outstanding-use counters; out-of-range RCA ids match no counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_RCAS; r++) count[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_RCAS; r++) begin
        count[r] <= next_count(count[r],
                               bus.use_issue    && (bus.use_issue_rca    == RW'(r)),
                               bus.use_complete && (bus.use_complete_rca == RW'(r)));
      end
    end
  end

  // Flatten registered state onto the output buses; blocking decodes state only.
  always_comb begin
    src_flat  = '0;
    dest_flat = '0;
    cnt_flat  = '0;
    blocked   = '0;
    for (int r = 0; r < NUM_RCAS; r++) begin
      for (int p = 0; p < NUM_READ_PORTS; p++) begin
        src_flat[(r*NUM_READ_PORTS+p)*5 +: 5] = active_src[r][p];
      end
      for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
        dest_flat[(r*NUM_WRITE_PORTS+p)*5 +: 5] = active_dest[r][p];
      end
      cnt_flat[r*CW +: CW] = count[r];
      blocked[r] = (state == DRAIN) && (commit_rca == RW'(r));
    end
  end

  assign bus.cfg_ready          = (state == IDLE);
  assign bus.cfg_error          = err_pulse;
  assign bus.commit_done        = done_pulse;
  assign bus.rca_blocked        = blocked;
  assign bus.rca_src_reg_addrs  = src_flat;
  assign bus.rca_dest_reg_addrs = dest_flat;
  assign bus.inflight_count     = cnt_flat;

endmodule

// File: doc/rca_config_bank.md
Name: rca_config_bank

Overview:
- Per-RCA configuration register bank for the reconfigurable-accelerator (RCA) path.
- Holds a shadow (staged) and an active copy of source and destination register-address maps for every RCA.
- Config instructions write the shadow copy; a commit copies shadow to active atomically, only once all in-flight RCA-use instructions on that RCA have completed.
- Drives the address maps consumed by issue and writeback, and stalls issue to an RCA while its commit is pending.

Parameters:
NUM_RCAS, 3, number of accelerators (>=1)
NUM_READ_PORTS, 5, source register slots per RCA
NUM_WRITE_PORTS, 4, destination register slots per RCA
MAX_INFLIGHT, 8, max outstanding use instructions per RCA; counter width CW = clog2(MAX_INFLIGHT+1)
Derived: RW = max(1, clog2(NUM_RCAS)); PW = max(1, clog2(max(NUM_READ_PORTS, NUM_WRITE_PORTS)))

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cfg_valid  in  1  config write request
cfg_ready  out  1  bank can accept a config write
cfg_rca_sel  in  RW  target RCA
cfg_port_sel  in  PW  slot index
cfg_src_dest  in  1  0 = source slot, 1 = destination slot
cfg_reg_addr  in  5  register address to store
cfg_commit  in  1  commit this RCA's shadow to active after this write
cfg_error  out  1  one-cycle pulse: write rejected, index out of range
commit_done  out  1  one-cycle pulse: active copy updated
use_issue  in  1  RCA-use instruction issued
use_issue_rca  in  RW  RCA of the issued instruction
use_complete  in  1  RCA-use instruction completed
use_complete_rca  in  RW  RCA of the completed instruction
rca_blocked  out  NUM_RCAS  bit k = 1: issue to RCA k must stall
rca_src_reg_addrs  out  NUM_RCAS*NUM_READ_PORTS*5  active source maps; RCA-major, slot-minor
rca_dest_reg_addrs  out  NUM_RCAS*NUM_WRITE_PORTS*5  active destination maps
inflight_count  out  NUM_RCAS*CW  per-RCA outstanding-use counters

Behaviour:
- Reset: shadow, active, and counters all 0; FSM = IDLE; cfg_ready = 1; cfg_error = 0; commit_done = 0; rca_blocked = 0. Reset mid-DRAIN or mid-COMMIT discards the pending commit.
- Accept: cfg_valid & cfg_ready. cfg_ready = (state == IDLE).
- Write:
  - The accepted write updates shadow[rca][src/dest][port] on the next edge.
  - If port >= NUM_READ_PORTS (src) or port >= NUM_WRITE_PORTS (dest), or rca >= NUM_RCAS: no write, no commit, and cfg_error pulses the next cycle.
- FSM IDLE -> DRAIN: accepted, valid write with cfg_commit = 1. Latch commit_rca. The same write is included in the commit.
- FSM DRAIN:
  - rca_blocked[commit_rca] = 1.
  - Stay while inflight[commit_rca] != 0, or use_issue targets commit_rca this cycle (protocol violation, still counted).
  - Otherwise -> COMMIT.
- FSM COMMIT:
  - active[commit_rca] <= shadow[commit_rca] (all src and dest slots).
  - commit_done pulses the next cycle.
  - -> IDLE.
- Commit latency: with count 0, write accepted in cycle T -> DRAIN T+1 -> COMMIT T+2. New map visible, commit_done = 1 and cfg_ready = 1 in T+3.
- Other RCAs' active maps never change during a commit; their issue is never blocked.
- Counters (per RCA k): inc = use_issue & rca == k; dec = use_complete & rca == k.
  - inc & dec: hold.
  - inc at MAX_INFLIGHT: hold (saturate, violation).
  - dec at 0: hold.
- Out-of-range use_issue_rca / use_complete_rca: ignored.
- Shadow writes to RCA j while IDLE do not affect active[j] until its own commit.
- All outputs are registered except rca_blocked and cfg_ready, which decode the FSM state only (no input-to-output paths).

Test Plan:
- After reset, write RCA1 src slot 2 = 7 with commit; counts 0 -> rca_src_reg_addrs[RCA1][2] = 7 and commit_done at T+3; cfg_ready low T+1..T+2; all other fields 0.
- Issue 3 uses to RCA0, then commit RCA0 dest slot 0 = 31 -> stays in DRAIN with rca_blocked = 3'b001 until 3 completes; active updated 2 cycles after the last complete.
- Simultaneous issue and complete on RCA2 at count 1 -> count stays 1; 9 issues at MAX_INFLIGHT = 8 -> count saturates at 8.
- Write src port 5 (NUM_READ_PORTS = 5) with commit -> cfg_error pulse; state stays IDLE; no map change.
- Write shadow RCA0 src0 = 4 without commit, then commit RCA1 -> RCA0 active src0 still 0; a later RCA0 commit shows 4.
- Assert rst in DRAIN -> next cycle IDLE, maps and counters 0, commit_done never pulses.
